// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: registered fetch PC, prioritised redirects, fetch handshake and WFI halt.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_CHK_EN.
module pc_gen #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_en,
    input  logic            br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic            jal_en,
    input  logic [PC_W-1:0] jal_target,
    input  logic            jalr_en,
    input  logic [PC_W-1:0] jalr_base,
    input  logic [PC_W-1:0] jalr_off,
    input  logic            trap_en,
    input  logic [PC_W-1:0] trap_vec,
    input  logic            mret_en,
    input  logic [PC_W-1:0] mepc,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            if_ready,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_add4,
    output logic            if_valid,
    output logic            redirect,
    output logic            misalign_exc,
    output logic [PC_W-1:0] bad_addr,
    output logic [1:0]      dbg_state_o
);

    // Handshake: a fetch at pc is consumed on a rising edge where if_valid && if_ready && !stall;
    // only then does the PC advance sequentially. Redirects flush and ignore if_ready.
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] jalr_tgt;
    logic [PC_W-1:0] other_tgt;
    logic            run_go;
    logic            take_other;

`ifdef PC_MISALIGN_CHK_EN
    logic            exc_q, exc_d;
    logic [PC_W-1:0] bad_q, bad_d;
`endif

    always_comb begin
        pc_add4    = pc_q + PC_W'(4);
        jalr_tgt   = (jalr_base + jalr_off) & ~PC_W'(1);
        run_go     = (state_q == ST_RUN) && !stall;
        take_other = run_go && (mret_en || jalr_en || jal_en || (br_en && br_cond));
        redirect   = trap_en || take_other;
        if_valid   = (state_q == ST_RUN);

        if (mret_en)      other_tgt = mepc;
        else if (jalr_en) other_tgt = jalr_tgt;
        else if (jal_en)  other_tgt = jal_target;
        else              other_tgt = br_target;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_MISALIGN_CHK_EN
        exc_d   = 1'b0;
        bad_d   = bad_q;
`endif
        if (trap_en) begin
            pc_d    = trap_vec;
            state_d = ST_RUN;
        end else if (take_other) begin
`ifdef PC_MISALIGN_CHK_EN
            // A target that is not word-aligned is diverted to the trap vector.
            if (other_tgt[1]) begin
                pc_d  = trap_vec;
                exc_d = 1'b1;
                bad_d = other_tgt;
            end else begin
                pc_d = other_tgt;
            end
`else
            pc_d = other_tgt & ~PC_W'(3);
`endif
        end else begin
            unique case (state_q)
                ST_START: state_d = ST_RUN;
                ST_RUN: begin
                    if (halt_req && !stall) begin
                        pc_d    = pc_add4;
                        state_d = ST_HALT;
                    end else if (if_valid && if_ready && !stall) begin
                        pc_d = pc_add4;
                    end
                end
                ST_HALT: begin
                    if (resume) state_d = ST_RUN;
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_START;
            pc_q    <= RESET_VEC;
`ifdef PC_MISALIGN_CHK_EN
            exc_q   <= 1'b0;
            bad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef PC_MISALIGN_CHK_EN
            exc_q   <= exc_d;
            bad_q   <= bad_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign dbg_state_o = state_q;

`ifdef PC_MISALIGN_CHK_EN
    assign misalign_exc = exc_q;
    assign bad_addr     = bad_q;
`else
    assign misalign_exc = 1'b0;
    assign bad_addr     = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: reset, sequencing, redirect priority, stall, halt and wrap.
module tb_pc_gen;

  localparam logic [31:0] S_START = 32'd0;
  localparam logic [31:0] S_RUN   = 32'd1;
  localparam logic [31:0] S_HALT  = 32'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_en, br_cond, jal_en, jalr_en, trap_en, mret_en;
  logic        halt_req, resume, if_ready;
  logic [31:0] br_target, jal_target, jalr_base, jalr_off, trap_vec, mepc;
  logic [31:0] pc, pc_add4, bad_addr;
  logic        if_valid, redirect, misalign_exc;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(.PC_W(32), .RESET_VEC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_en(br_en), .br_cond(br_cond), .br_target(br_target),
    .jal_en(jal_en), .jal_target(jal_target),
    .jalr_en(jalr_en), .jalr_base(jalr_base), .jalr_off(jalr_off),
    .trap_en(trap_en), .trap_vec(trap_vec),
    .mret_en(mret_en), .mepc(mepc),
    .halt_req(halt_req), .resume(resume), .if_ready(if_ready),
    .pc(pc), .pc_add4(pc_add4), .if_valid(if_valid), .redirect(redirect),
    .misalign_exc(misalign_exc), .bad_addr(bad_addr), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; br_en = 0; br_cond = 0; jal_en = 0; jalr_en = 0;
    trap_en = 0; mret_en = 0; halt_req = 0; resume = 0;
    #1;
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    jal_en = 1; jal_target = tgt;
    tick();
    clear_ctl();
  endtask

  initial begin
    rst_n = 0; if_ready = 1;
    br_target = 0; jal_target = 0; jalr_base = 0; jalr_off = 0; trap_vec = 0; mepc = 0;
    clear_ctl();
    repeat (3) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_exc", {31'b0, misalign_exc}, 32'd0);
    check("rst_bad", bad_addr, 32'h0);
    check("rst_state", {30'b0, dbg_state}, S_START);

    rst_n = 1; #1;
    check("c0_pc", pc, 32'h0);
    check("c0_valid", {31'b0, if_valid}, 32'd0);
    tick();
    check("c1_pc", pc, 32'h0);
    check("c1_valid", {31'b0, if_valid}, 32'd1);
    tick(); check("seq_4", pc, 32'h4);
    tick(); check("seq_8", pc, 32'h8);
    if_ready = 0;
    tick(); check("hold_8a", pc, 32'h8);
    tick(); check("hold_8b", pc, 32'h8);
    check("add4_8", pc_add4, 32'hC);
    if_ready = 1;
    tick(); check("seq_12", pc, 32'hC);

    // Branch taken / not taken from 0x20
    jump_to(32'h20);
    check("jal_20", pc, 32'h20);
    check("redir_low", {31'b0, redirect}, 32'd0);
    br_en = 1; br_cond = 1; br_target = 32'h100; #1;
    check("br_redir", {31'b0, redirect}, 32'd1);
    tick(); clear_ctl();
    check("br_taken", pc, 32'h100);
    check("br_redir_gone", {31'b0, redirect}, 32'd0);
    jump_to(32'h20);
    br_en = 1; br_cond = 0; br_target = 32'h100; #1;
    check("br_nt_redir", {31'b0, redirect}, 32'd0);
    tick(); clear_ctl();
    check("br_not_taken", pc, 32'h24);

    // JALR beats JAL and branch; LSB cleared
    jalr_en = 1; jalr_base = 32'h1001; jalr_off = 32'h4;
    jal_en = 1; jal_target = 32'h200; br_en = 1; br_cond = 1; br_target = 32'h300;
    tick(); clear_ctl();
    check("jalr_prio", pc, 32'h1004);

    // MRET beats JALR
    mret_en = 1; mepc = 32'h500; jalr_en = 1;
    tick(); clear_ctl();
    check("mret_prio", pc, 32'h500);

    // Wrap-around
    jump_to(32'hFFFF_FFFC);
    check("add4_wrap", pc_add4, 32'h0);
    tick(); check("seq_wrap", pc, 32'h0);
    jalr_en = 1; jalr_base = 32'hFFFF_FFF0; jalr_off = 32'h14;
    tick(); clear_ctl();
    check("jalr_wrap", pc, 32'h4);

    // Stall: trap still accepted, branch is not
    stall = 1; br_en = 1; br_cond = 1; br_target = 32'h100;
    trap_en = 1; trap_vec = 32'h80; #1;
    check("stall_trap_redir", {31'b0, redirect}, 32'd1);
    tick();
    check("stall_trap", pc, 32'h80);
    trap_en = 0; #1;
    check("stall_br_redir", {31'b0, redirect}, 32'd0);
    tick(); tick();
    check("stall_hold", pc, 32'h80);
    clear_ctl();

    // Halt, then resume
    jump_to(32'h40);
    check("at_40", pc, 32'h40);
    halt_req = 1;
    tick(); clear_ctl();
    check("halt_pc", pc, 32'h44);
    check("halt_state", {30'b0, dbg_state}, S_HALT);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_valid", {31'b0, if_valid}, 32'd0);
    end
    check("halt_pc_held", pc, 32'h44);
    resume = 1;
    tick(); clear_ctl();
    check("resume_state", {30'b0, dbg_state}, S_RUN);
    check("resume_valid", {31'b0, if_valid}, 32'd1);
    check("resume_pc", pc, 32'h44);
    tick(); check("resume_seq", pc, 32'h48);

    // Halt again, exit with trap (trap and resume together)
    halt_req = 1;
    tick(); clear_ctl();
    check("halt2_pc", pc, 32'h4C);
    tick(); check("halt2_hold", pc, 32'h4C);
    trap_en = 1; trap_vec = 32'h80; resume = 1;
    tick(); clear_ctl();
    check("halt_trap_pc", pc, 32'h80);
    check("halt_trap_state", {30'b0, dbg_state}, S_RUN);

    // halt_req with redirect: redirect wins
    halt_req = 1; jal_en = 1; jal_target = 32'h300;
    tick(); clear_ctl();
    check("halt_vs_jal_pc", pc, 32'h300);
    check("halt_vs_jal_state", {30'b0, dbg_state}, S_RUN);

    // Misaligned JAL target
    jal_en = 1; jal_target = 32'h102; trap_vec = 32'h80; #1;
    check("mis_redir", {31'b0, redirect}, 32'd1);
    tick(); clear_ctl();
`ifdef PC_MISALIGN_CHK_EN
    check("mis_pc", pc, 32'h80);
    check("mis_exc", {31'b0, misalign_exc}, 32'd1);
    check("mis_bad", bad_addr, 32'h102);
    tick();
    check("mis_exc_pulse", {31'b0, misalign_exc}, 32'd0);
    check("mis_bad_held", bad_addr, 32'h102);
`else
    check("mis_pc", pc, 32'h100);
    check("mis_exc", {31'b0, misalign_exc}, 32'd0);
    check("mis_bad", bad_addr, 32'h0);
`endif

    // Reset during HALT
    halt_req = 1;
    tick(); clear_ctl();
    check("pre_rst_state", {30'b0, dbg_state}, S_HALT);
    rst_n = 0;
    tick();
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_state", {30'b0, dbg_state}, S_START);
    check("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    check("mid_rst_exc", {31'b0, misalign_exc}, 32'd0);
    rst_n = 1;
    tick();
    check("post_rst_state", {30'b0, dbg_state}, S_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
